// File: rtl/decode_pkg.sv
// Shared constants, instruction field layout and decode helpers for the
// decode/issue stage.
package decode_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_STORE = 6'b011111;

  typedef struct packed {
    logic          is_i;
    logic [5:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [6:0]    imm7;
  } instr_f_t;

  // Both forms share op and rd positions; bit 15 is not part of the opcode.
  function automatic instr_f_t decode_fields(input logic [15:0] instr);
    instr_f_t f;
    f.is_i = instr[15];
    f.op   = {1'b0, instr[14:10]};
    f.rd   = instr[9:7];
    f.rs   = instr[6:4];
    f.rt   = instr[3:1];
    f.imm7 = instr[6:0];
    return f;
  endfunction

  function automatic logic [DW-1:0] sext7(input logic [6:0] imm);
    return {{(DW-7){imm[6]}}, imm};
  endfunction

  function automatic logic writes_rd(input logic [5:0] op);
    return (op != OP_NOP) && (op != OP_STORE);
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch-side, write-back and issue signals of the decode/issue stage.
import decode_pkg::*;

interface decode_issue_if;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [5:0]    op_dec;
  logic [DW-1:0] data_in;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;

  modport master (
    output instr, instr_valid, wb_en, wb_addr, wb_data,
    input  instr_ready, A, B, op_dec, data_in, issue_valid, issue_rd
  );

  modport slave (
    input  instr, instr_valid, wb_en, wb_addr, wb_data,
    output instr_ready, A, B, op_dec, data_in, issue_valid, issue_rd
  );
endinterface

// File: rtl/regfile_bypass.sv
// 8x16 register file with three combinational read ports, one write port,
// write-back bypass onto reads, and R0 hardwired to zero.
import decode_pkg::*;

module regfile_bypass (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_a,
    input  logic [AW-1:0] ra_b,
    input  logic [AW-1:0] ra_c,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    output logic [DW-1:0] rd_c
);

    logic [DW-1:0] regs [NREG];
    logic          wr_live;

    assign wr_live = we && (waddr != '0);

    // NOTE: the file must clear on reset, so every entry sits on the async
    // reset; a memory without that requirement would stay reset-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra);
        if (ra == '0)                  return '0;
        if (wr_live && (ra == waddr))  return wdata;
        return regs[ra];
    endfunction

    assign rd_a = read_port(ra_a);
    assign rd_b = read_port(ra_b);
    assign rd_c = read_port(ra_c);

endmodule

// File: rtl/decode_issue.sv
// Decode/operand-fetch stage: pending-write scoreboard, hazard stall and
// registered issue of operands to ExeBlock.
import decode_pkg::*;

module decode_issue (
    input logic            clk,
    input logic            reset,
    decode_issue_if.slave  bus
);

    instr_f_t      f;
    logic          wr_op;
    logic          accept;
    logic          hazard;
    logic [AW-1:0] ra_a;
    logic [DW-1:0] rd_a, rd_b, rd_c;
    logic [DW-1:0] opnd_b;
    logic [NREG-1:0] pending, wb_clr, busy, set_vec;

    assign f      = decode_fields(bus.instr);
    assign wr_op  = writes_rd(f.op);
    assign ra_a   = f.is_i ? f.rd : f.rs;
    assign opnd_b = f.is_i ? sext7(f.imm7) : rd_b;

    regfile_bypass u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (bus.wb_en),
        .waddr (bus.wb_addr),
        .wdata (bus.wb_data),
        .ra_a  (ra_a),
        .ra_b  (f.rt),
        .ra_c  (f.rd),
        .rd_a  (rd_a),
        .rd_b  (rd_b),
        .rd_c  (rd_c)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        wb_clr  = '0;
        set_vec = '0;
        if (bus.wb_en && (bus.wb_addr != '0)) wb_clr[bus.wb_addr] = 1'b1;
        if (accept && wr_op && (f.rd != '0))  set_vec[f.rd] = 1'b1;
    end

    // A write-back landing this cycle releases its register immediately.
    assign busy = pending & ~wb_clr;

    always_comb begin
        hazard = busy[f.rd] && (wr_op || f.is_i || (f.op == OP_STORE));
        if (!f.is_i) hazard = hazard || busy[f.rs] || busy[f.rt];
    end

    assign bus.instr_ready = !hazard;
    assign accept          = bus.instr_valid && bus.instr_ready;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            // Set after clear: a new owner wins over a retiring write.
            pending <= (pending & ~wb_clr) | set_vec;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.A           <= '0;
            bus.B           <= '0;
            bus.data_in     <= '0;
            bus.op_dec      <= OP_NOP;
            bus.issue_valid <= 1'b0;
            bus.issue_rd    <= '0;
        end else if (accept) begin
            bus.A           <= rd_a;
            bus.B           <= opnd_b;
            bus.data_in     <= rd_c;
            bus.op_dec      <= f.op;
            bus.issue_valid <= 1'b1;
            bus.issue_rd    <= f.rd;
        end else begin
            bus.op_dec      <= OP_NOP;
            bus.issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: expected issues are queued by the
// stimulus and checked by an independent monitor on the falling edge.
import decode_pkg::*;

module tb_decode_issue;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [5:0]    op;
        logic [DW-1:0] din;
        logic [AW-1:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 1'b0;
    exp_t q [$];

    decode_issue_if bus ();

    decode_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [5:0] op, input logic [DW-1:0] din,
                                input logic [AW-1:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.din = din; e.rd = rd;
        return e;
    endfunction

    // Monitor: pops one expectation for every cycle the DUT presents an issue.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (bus.issue_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_issue", {31'b0, bus.issue_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("A",        {16'b0, bus.A},        {16'b0, e.a});
                    check("B",        {16'b0, bus.B},        {16'b0, e.b});
                    check("op_dec",   {26'b0, bus.op_dec},   {26'b0, e.op});
                    check("data_in",  {16'b0, bus.data_in},  {16'b0, e.din});
                    check("issue_rd", {29'b0, bus.issue_rd}, {29'b0, e.rd});
                end
            end else begin
                check("idle_op_dec", {26'b0, bus.op_dec}, {26'b0, OP_NOP});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [15:0] ins, input exp_t e, input bit must_ready);
        int n;
        @(posedge clk); #1;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        if (must_ready) check("no_stall", {31'b0, bus.instr_ready}, 32'd1);
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.instr_ready !== 1'b1) check("accept_timeout", {31'b0, bus.instr_ready}, 32'd1);
        else q.push_back(e);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wb(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(posedge clk); #1;
        bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
        @(posedge clk); #1;
        bus.wb_en = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_A",           {16'b0, bus.A},       32'd0);
        check("rst_B",           {16'b0, bus.B},       32'd0);
        check("rst_data_in",     {16'b0, bus.data_in}, 32'd0);
        check("rst_op_dec",      {26'b0, bus.op_dec},  32'd0);
        check("rst_issue_valid", {31'b0, bus.issue_valid}, 32'd0);
        check("rst_issue_rd",    {29'b0, bus.issue_rd},    32'd0);
        check("rst_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
    endtask

    initial begin
        bus.instr = 16'h0B26;
        bus.instr_valid = 1'b0;
        bus.wb_en = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        #3;
        check_reset_outputs();
        #9 reset = 1'b1;

        // I-form sign extension, both signs of imm7.
        send(16'h80BF, mk(16'h0000, 16'h003F, 6'h00, 16'h0000, 3'd1), 1'b1);
        send(16'h80C1, mk(16'h0000, 16'hFFC1, 6'h00, 16'h0000, 3'd1), 1'b1);

        // I-form writing op: A = R[rd], then retire its pending bit.
        wb(3'd3, 16'h0008);
        send(16'h95FF, mk(16'h0008, 16'hFFFF, 6'h05, 16'h0008, 3'd3), 1'b1);
        wb(3'd3, 16'h0008);

        // Store leaves R3 free; a following reader of R3 does not stall.
        send(16'h7D80, mk(16'h0000, 16'h0000, 6'h1F, 16'h0008, 3'd3), 1'b1);
        send(16'h06B0, mk(16'h0008, 16'h0000, 6'h01, 16'h0000, 3'd5), 1'b1);
        wb(3'd5, 16'h1234);

        // RAW stall on R2, released by a same-cycle write-back with bypass.
        send(16'h0500, mk(16'h0000, 16'h0000, 6'h01, 16'h0000, 3'd2), 1'b1);
        bus.instr = 16'h0B26;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("raw_stall_ready", {31'b0, bus.instr_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'h4000;
        @(negedge clk);
        check("raw_release_ready", {31'b0, bus.instr_ready}, 32'd1);
        q.push_back(mk(16'h4000, 16'h0008, 6'h02, 16'h0000, 3'd6));
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.wb_en = 1'b0;

        // R0 ignores writes and never becomes pending.
        wb(3'd0, 16'hFFFF);
        send(16'h0C04, mk(16'h0000, 16'h4000, 6'h03, 16'h0000, 3'd0), 1'b1);
        send(16'h0C04, mk(16'h0000, 16'h4000, 6'h03, 16'h0000, 3'd0), 1'b1);

        // Same-cycle clear and set of R4: the new owner keeps it pending.
        send(16'h0600, mk(16'h0000, 16'h0000, 6'h01, 16'h0000, 3'd4), 1'b1);
        bus.instr = 16'h0640;
        bus.instr_valid = 1'b1;
        bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.wb_data = 16'h0ABC;
        @(negedge clk);
        check("clr_set_ready", {31'b0, bus.instr_ready}, 32'd1);
        q.push_back(mk(16'h0ABC, 16'h0000, 6'h01, 16'h0ABC, 3'd4));
        @(posedge clk); #1;
        bus.wb_en = 1'b0;
        bus.instr = 16'h0C40;
        @(negedge clk);
        check("set_wins_stall", {31'b0, bus.instr_ready}, 32'd0);
        @(posedge clk); #1;
        bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.wb_data = 16'h5555;
        @(negedge clk);
        check("r4_release_ready", {31'b0, bus.instr_ready}, 32'd1);
        q.push_back(mk(16'h5555, 16'h0000, 6'h03, 16'h0000, 3'd0));
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.wb_en = 1'b0;

        // Reset mid-stream: accepted R-form is discarded along with all state.
        @(posedge clk); #1;
        bus.instr = 16'h0500;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr = 16'h0B26;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        #2 reset = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'b0, bus.instr_ready}, 32'd1);
        q.push_back(mk(16'h0000, 16'h0000, 6'h02, 16'h0000, 3'd6));
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        done = 1'b1;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
